// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the UART program/data loader.
//   rx_state_e : receive bit-FSM states (PARITY only used in 8E1 builds)
//   BYTE_WID   : width of one UART character
//   DATA_WID   : width of an assembled memory word
//   ADDR_STEP  : byte-address increment between consecutive words
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int BYTE_WID  = 8;
  localparam int DATA_WID  = 32;
  localparam int ADDR_STEP = 4;

endpackage

// File: rtl/uart_rx_byte.sv
// ---------------------------------------------------------------------------
// uart_rx_byte
//   Synchronises the asynchronous rx line (2 flops) and deserialises one
//   UART character at a time, LSB first, sampling each bit at its centre.
//   Build option: define UART_LOADER_PARITY_EN for 8E1 framing (an even-parity
//   bit follows the data bits); otherwise 8N1.
// Ports
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   rx         in   asynchronous UART line, idle high
//   rx_byte    out  last received character (valid with byte_vld)
//   byte_vld   out  one-cycle strobe: character accepted at the stop sample
//   frame_err  out  one-cycle strobe: bad stop bit (or parity) at the stop sample
//   rx_idle    out  bit FSM is in IDLE
//   rx_level   out  synchronised line level
//   start_edge out  falling edge of the synchronised line
// ---------------------------------------------------------------------------
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  output logic [BYTE_WID-1:0] rx_byte,
  output logic                byte_vld,
  output logic                frame_err,
  output logic                rx_idle,
  output logic                rx_level,
  output logic                start_edge
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(DIV / 2);
  localparam logic [CW-1:0] FULL_CNT = CW'(DIV - 1);

  rx_state_e           state;
  rx_state_e           next_state;
  logic                rx_meta;
  logic                rx_sync;
  logic                rx_prev;
  logic [CW-1:0]       cnt;
  logic [2:0]          bit_idx;
  logic [BYTE_WID-1:0] shreg;
  logic                par_bad;
  logic                sample;

  // Two-flop synchroniser plus one more stage for edge detection; all reset to
  // the idle-high level so reset release never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign start_edge = rx_prev & ~rx_sync;
  assign rx_level   = rx_sync;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // The start bit is checked half a bit in; every later sample is one full bit
  // after the previous one, which keeps all samples bit-centred.
  always_comb begin
    sample = 1'b0;
    case (state)
      START:   sample = (cnt == HALF_CNT);
      DATA, PARITY, STOP: sample = (cnt == FULL_CNT);
      default: sample = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (start_edge) next_state = START;
      START:  if (sample) next_state = rx_sync ? IDLE : DATA;
      DATA: begin
        if (sample && bit_idx == 3'd7) begin
`ifdef UART_LOADER_PARITY_EN
          next_state = PARITY;
`else
          next_state = STOP;
`endif
        end
      end
      PARITY: if (sample) next_state = STOP;
      STOP:   if (sample) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Bit timer, bit index, shift register and parity check.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else begin
      if (state == IDLE || sample) cnt <= '0;
      else                         cnt <= cnt + 1'b1;
      if (state == START) begin
        bit_idx <= '0;
        par_bad <= 1'b0;
      end
      if (state == DATA && sample) begin
        shreg   <= {rx_sync, shreg[BYTE_WID-1:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      // Even parity: data bits plus parity bit must have an even number of ones.
      if (state == PARITY && sample) par_bad <= rx_sync ^ (^shreg);
    end
  end

  // Outputs: decisions are made at the stop sample so the FSM is back in IDLE
  // on the same edge the strobe is consumed.
  always_comb begin
    rx_idle   = (state == IDLE);
    rx_byte   = shreg;
    byte_vld  = 1'b0;
    frame_err = 1'b0;
    if (state == STOP && sample) begin
      byte_vld  = rx_sync & ~par_bad;
      frame_err = ~rx_sync | par_bad;
    end
  end

endmodule

// File: rtl/uart_loader.sv
// ---------------------------------------------------------------------------
// uart_loader
//   Serial program/data loader. Receives UART characters, packs them
//   little-endian into 32-bit words at auto-incrementing byte addresses and
//   strobes each word to the CPU. A long idle line after at least one word
//   ends the transfer (sticky done); after that all traffic is ignored.
//   Build option: UART_LOADER_PARITY_EN selects 8E1 framing (default 8N1).
// Ports
//   clk       in   system clock
//   rst       in   synchronous reset, active-high
//   rx        in   asynchronous UART line, idle high
//   data_out  out  assembled word, valid while we=1, held otherwise
//   addr_out  out  byte address of data_out (multiple of 4)
//   we        out  one-cycle word-write strobe
//   done      out  sticky: transfer finished
//   err       out  sticky: framing (or parity) error seen
// ---------------------------------------------------------------------------
module uart_loader
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD        = 115_200,
  parameter int IDLE_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  output logic [DATA_WID-1:0] data_out,
  output logic [DATA_WID-1:0] addr_out,
  output logic                we,
  output logic                done,
  output logic                err
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam logic [31:0] IDLE_MAX = 32'(IDLE_CYCLES);

  logic [BYTE_WID-1:0]          rx_byte;
  logic                         byte_vld;
  logic                         frame_err;
  logic                         rx_idle;
  logic                         rx_level;
  logic                         start_edge;
  logic [1:0]                   byte_cnt;
  logic [DATA_WID-BYTE_WID-1:0] word_buf;
  logic [DATA_WID-1:0]          word_addr;
  logic                         have_word;
  logic [31:0]                  idle_timer;
  logic                         idle_count;

  uart_rx_byte #(.DIV(DIV)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_byte    (rx_byte),
    .byte_vld   (byte_vld),
    .frame_err  (frame_err),
    .rx_idle    (rx_idle),
    .rx_level   (rx_level),
    .start_edge (start_edge)
  );

  // The timer saturates at IDLE_MAX so an empty transfer never wraps around.
  assign idle_count = rx_idle && rx_level && (idle_timer != IDLE_MAX);

  // Word packer, address counter, idle timer and sticky flags. Once done is
  // set nothing but reset changes the outputs again.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      addr_out   <= '0;
      we         <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      byte_cnt   <= '0;
      word_buf   <= '0;
      word_addr  <= '0;
      have_word  <= 1'b0;
      idle_timer <= '0;
    end else begin
      we <= 1'b0;
      if (!done) begin
        if (frame_err) begin
          err      <= 1'b1;
          byte_cnt <= '0;
        end else if (byte_vld) begin
          if (byte_cnt == 2'd3) begin
            data_out  <= {rx_byte, word_buf};
            addr_out  <= word_addr;
            word_addr <= word_addr + DATA_WID'(ADDR_STEP);
            we        <= 1'b1;
            have_word <= 1'b1;
            byte_cnt  <= '0;
          end else begin
            word_buf[{byte_cnt, 3'b000} +: BYTE_WID] <= rx_byte;
            byte_cnt <= byte_cnt + 1'b1;
          end
        end

        if (start_edge) idle_timer <= '0;
        else if (idle_count) idle_timer <= idle_timer + 1'b1;

        // done rises on the same edge the timer reaches IDLE_MAX.
        if (!start_edge && idle_count && have_word &&
            idle_timer == IDLE_MAX - 32'd1)
          done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_loader
//   Self-checking bench for uart_loader with CLK_FREQ=16, BAUD=1 (16 clocks
//   per bit) and IDLE_CYCLES=200. Define UART_LOADER_PARITY_EN for 8E1.
// ---------------------------------------------------------------------------
module tb_uart_loader;

  localparam int DIV  = 16;
  localparam int IDLE = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [31:0] data_out;
  logic [31:0] addr_out;
  logic        we;
  logic        done;
  logic        err;

  int vectors    = 0;
  int miscompares = 0;

  uart_loader #(.CLK_FREQ(16), .BAUD(1), .IDLE_CYCLES(IDLE)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data_out (data_out),
    .addr_out (addr_out),
    .we       (we),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Monitor: records every word strobe with its cycle number, the first cycle
  // done is seen, and any strobe that lasts longer than one cycle.
  int          cycle = 0;
  logic [31:0] got_data[$];
  logic [31:0] got_addr[$];
  int          got_cyc[$];
  int          done_cycle = -1;
  int          we_double = 0;
  logic        we_d = 1'b0;

  always @(negedge clk) begin
    cycle = cycle + 1;
    if (we === 1'b1) begin
      got_data.push_back(data_out);
      got_addr.push_back(addr_out);
      got_cyc.push_back(cycle);
      if (we_d === 1'b1) we_double = we_double + 1;
    end
    we_d = we;
    if (done === 1'b1 && done_cycle < 0) done_cycle = cycle;
  end

  // Reference model: the byte stream as the line carries it.
  logic [7:0]  mdl_part[$];
  logic [31:0] exp_data[$];
  logic [31:0] exp_addr[$];
  logic [31:0] mdl_addr;
  logic        mdl_err;

  task automatic model_clear();
    mdl_part.delete();
    exp_data.delete();
    exp_addr.delete();
    mdl_addr = 32'd0;
    mdl_err  = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic good);
    if (!good) begin
      mdl_err = 1'b1;
      mdl_part.delete();
    end else begin
      mdl_part.push_back(b);
      if (mdl_part.size() == 4) begin
        exp_data.push_back({mdl_part[3], mdl_part[2], mdl_part[1], mdl_part[0]});
        exp_addr.push_back(mdl_addr);
        mdl_addr = mdl_addr + 32'd4;
        mdl_part.delete();
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_data.delete();
    got_addr.delete();
    got_cyc.delete();
    done_cycle = -1;
    we_double  = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    rx  = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(4);
    clear_mon();
    model_clear();
  endtask

  // One frame: start, 8 data bits LSB first, optional even parity, stop.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(DIV);
    end
`ifdef UART_LOADER_PARITY_EN
    rx = (^b) ^ par_flip;
    tick(DIV);
`else
    if (par_flip) $display("[TB] note: parity flip ignored in 8N1 build");
`endif
    rx = stop_bit;
    tick(DIV);
    rx = 1'b1;
    if (!stop_bit) tick(DIV);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b1, 1'b0);
    model_byte(b, 1'b1);
  endtask

  task automatic check_words(input string name);
    vectors++;
    if (got_data.size() != exp_data.size()) begin
      miscompares++;
      $display("[TB] FAIL %s word count: got %0d expected %0d", name, got_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size(); i++) begin
      vectors++;
      if (i >= got_data.size()) begin
        miscompares++;
        $display("[TB] FAIL %s word %0d missing: expected %h @ %h", name, i, exp_data[i], exp_addr[i]);
      end else if (got_data[i] !== exp_data[i] || got_addr[i] !== exp_addr[i]) begin
        miscompares++;
        $display("[TB] FAIL %s word %0d: got %h @ %h expected %h @ %h", name, i,
                 got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rx = 1'($urandom_range(0, 1));
      @(negedge clk);
      vectors++;
      if ({data_out, addr_out, we, done, err} !== 67'd0) begin
        miscompares++;
        $display("[TB] FAIL reset outputs: got d=%h a=%h we=%b done=%b err=%b expected all 0",
                 data_out, addr_out, we, done, err);
      end
      tick(1);
    end
    apply_reset();
  endtask

  task automatic test_single_word();
    apply_reset();
    send_good(8'h78); send_good(8'h56); send_good(8'h34); send_good(8'h12);
    tick(40);
    check_words("single_word");
    vectors++;
    if (done !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_word flags: got done=%b err=%b expected 0 0", done, err);
    end
  endtask

  task automatic test_done();
    apply_reset();
    for (int i = 1; i <= 8; i++) send_good(8'(i));
    tick(IDLE + 20);
    check_words("done_words");
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL done flag: got %b expected 1", done);
    end
    vectors++;
    if (got_cyc.size() < 2 || done_cycle - got_cyc[got_cyc.size()-1] != IDLE) begin
      miscompares++;
      $display("[TB] FAIL done timing: got done_cycle=%0d last_we_strobes=%0d expected gap %0d",
               done_cycle, got_cyc.size(), IDLE);
    end
    vectors++;
    if (we_double != 0) begin
      miscompares++;
      $display("[TB] FAIL we width: got %0d multi-cycle strobes expected 0", we_double);
    end
    for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b1, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0);
    tick(40);
    vectors++;
    if (got_data.size() != 2 || err !== 1'b0 || done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL after_done: got words=%0d err=%b done=%b expected 2 0 1",
               got_data.size(), err, done);
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(60);
    vectors++;
    if (got_data.size() != 0 || err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL glitch: got words=%0d err=%b expected 0 0", got_data.size(), err);
    end
    send_good(8'hDE); send_good(8'hAD); send_good(8'hBE); send_good(8'hEF);
    tick(40);
    check_words("glitch_recover");
  endtask

  task automatic test_framing();
    apply_reset();
    send_frame(8'hAA, 1'b0, 1'b0);
    model_byte(8'hAA, 1'b0);
    send_good(8'h11); send_good(8'h22); send_good(8'h33); send_good(8'h44);
    tick(40);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL framing err: got %b expected 1", err);
    end
    check_words("framing");
  endtask

  task automatic test_partial();
    apply_reset();
    send_good(8'hC1); send_good(8'hC2); send_good(8'hC3);
    tick(300);
    vectors++;
    if (got_data.size() != 0 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL partial: got words=%0d done=%b expected 0 0", got_data.size(), done);
    end
  endtask

  task automatic test_reset_mid_byte();
    apply_reset();
    send_good(8'hF0); send_good(8'hE1); send_good(8'hD2); send_good(8'hC3);
    send_frame(8'h99, 1'b1, 1'b0);
    rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 5; i++) begin
      rx = 1'($urandom_range(0, 1));
      tick(DIV);
    end
    rst = 1'b1;
    tick(DIV / 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({data_out, addr_out, we, done, err} !== 67'd0) begin
        miscompares++;
        $display("[TB] FAIL mid_reset outputs: got d=%h a=%h we=%b done=%b err=%b expected all 0",
                 data_out, addr_out, we, done, err);
      end
      tick(1);
    end
    rx  = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
    clear_mon();
    model_clear();
    send_good(8'h0A); send_good(8'h0B); send_good(8'h0C); send_good(8'h0D);
    tick(40);
    check_words("mid_reset");
  endtask

  task automatic test_back_to_back();
    for (int run = 0; run < 3; run++) begin
      int n;
      apply_reset();
      n = $urandom_range(6, 14);
      for (int i = 0; i < n; i++) begin
        logic [7:0] b;
        logic       good;
        b    = 8'($urandom);
        good = ($urandom_range(0, 4) != 0);
        send_frame(b, good, 1'b0);
        model_byte(b, good);
        if ($urandom_range(0, 1) == 1) tick($urandom_range(1, 30));
      end
      tick(40);
      check_words("random_stream");
      vectors++;
      if (err !== mdl_err) begin
        miscompares++;
        $display("[TB] FAIL random err: got %b expected %b", err, mdl_err);
      end
      tick(IDLE + 20);
      vectors++;
      if (done !== (exp_data.size() > 0)) begin
        miscompares++;
        $display("[TB] FAIL random done: got %b expected %b", done, exp_data.size() > 0);
      end
    end
  endtask

`ifdef UART_LOADER_PARITY_EN
  task automatic test_parity();
    apply_reset();
    send_frame(8'h03, 1'b1, 1'b1);
    model_byte(8'h03, 1'b0);
    send_good(8'h03); send_good(8'hA1); send_good(8'hB2); send_good(8'hC3);
    tick(40);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL parity err: got %b expected 1", err);
    end
    check_words("parity");
  endtask
`endif

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    test_reset();
    test_single_word();
    test_done();
    test_glitch();
    test_framing();
    test_partial();
    test_reset_mid_byte();
    test_back_to_back();
`ifdef UART_LOADER_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
